// File: rtl/wdt_window_if.sv
// Watchdog control/status bundle.
// master : config/kick driver (register block or testbench)
// slave  : wdt_window core
// Signals: en_i, kick_i, presc_i, timeout_i, window_i, warn_i, clear_cause_i
//          toward the core; sys_rst_o, warn_irq_o, cause_o, cnt_o, running_o
//          back from it.
interface wdt_window_if #(
  parameter int CntWidth   = 32,
  parameter int PrescWidth = 8
);
  logic                  en_i;
  logic                  kick_i;
  logic [PrescWidth-1:0] presc_i;
  logic [CntWidth-1:0]   timeout_i;
  logic [CntWidth-1:0]   window_i;
  logic [CntWidth-1:0]   warn_i;
  logic                  clear_cause_i;
  logic                  sys_rst_o;
  logic                  warn_irq_o;
  logic [1:0]            cause_o;
  logic [CntWidth-1:0]   cnt_o;
  logic                  running_o;

  modport master (
    output en_i, kick_i, presc_i, timeout_i, window_i, warn_i, clear_cause_i,
    input  sys_rst_o, warn_irq_o, cause_o, cnt_o, running_o
  );

  modport slave (
    input  en_i, kick_i, presc_i, timeout_i, window_i, warn_i, clear_cause_i,
    output sys_rst_o, warn_irq_o, cause_o, cnt_o, running_o
  );
endinterface

// File: rtl/wdt_window.sv
// Windowed watchdog timer with prescaler, early-kick window, pre-timeout
// warning pulse, fixed-length system reset pulse and sticky reset cause.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   bus (slave)   : config/kick inputs, sys_rst_o / warn_irq_o / cause_o /
//                   cnt_o / running_o outputs (see wdt_window_if)
// Build option: WDT_LOCK_EN -- capture presc/timeout/window/warn at the
//   IDLE->RUN transition and ignore en_i while running.
module wdt_window #(
  parameter int CntWidth       = 32,
  parameter int PrescWidth     = 8,
  parameter int RstPulseCycles = 16
) (
  input logic         clk_i,
  input logic         rst_ni,
  wdt_window_if.slave bus
);

  localparam int PulseW = $clog2(RstPulseCycles + 1);

  typedef enum logic [1:0] {IDLE, RUN, RST} state_t;

  state_t                state_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [PrescWidth-1:0] presc_q;
  logic [PulseW-1:0]     pulse_q;
  logic                  sys_rst_q;
  logic                  warn_irq_q;
  logic                  warn_armed_q;
  logic [1:0]            cause_q;
  logic                  running_q;

  logic [PrescWidth-1:0] cfg_presc;
  logic [CntWidth-1:0]   cfg_timeout, cfg_window, cfg_warn;
  logic                  stop_req;

`ifdef WDT_LOCK_EN
  logic [PrescWidth-1:0] sh_presc_q;
  logic [CntWidth-1:0]   sh_timeout_q, sh_window_q, sh_warn_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_presc_q   <= '0;
      sh_timeout_q <= '0;
      sh_window_q  <= '0;
      sh_warn_q    <= '0;
    end else if (state_q == IDLE && bus.en_i) begin
      sh_presc_q   <= bus.presc_i;
      sh_timeout_q <= bus.timeout_i;
      sh_window_q  <= bus.window_i;
      sh_warn_q    <= bus.warn_i;
    end
  end

  assign cfg_presc   = sh_presc_q;
  assign cfg_timeout = sh_timeout_q;
  assign cfg_window  = sh_window_q;
  assign cfg_warn    = sh_warn_q;
  assign stop_req    = 1'b0;
`else
  assign cfg_presc   = bus.presc_i;
  assign cfg_timeout = bus.timeout_i;
  assign cfg_window  = bus.window_i;
  assign cfg_warn    = bus.warn_i;
  assign stop_req    = !bus.en_i;
`endif

  // >= rather than == so a live shrink of presc_i below the current
  // prescaler value still ticks instead of running the prescaler around.
  logic                tick;
  logic [CntWidth-1:0] cnt_inc;
  logic                timeout_hit, early_hit, warn_ok;
  logic [1:0]          cause_set;

  assign tick        = (presc_q >= cfg_presc);
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign timeout_hit = (cnt_q >= cfg_timeout);
  assign early_hit   = bus.kick_i && (cfg_window != '0) && (cnt_q < cfg_window);
  assign warn_ok     = (cfg_warn != '0) && (cfg_warn < cfg_timeout);

  // Timeout outranks an early kick in the same cycle.
  always_comb begin
    cause_set = 2'b00;
    if (state_q == RUN) begin
      if (timeout_hit)    cause_set = 2'b01;
      else if (early_hit) cause_set = 2'b10;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      presc_q      <= '0;
      pulse_q      <= '0;
      sys_rst_q    <= 1'b0;
      warn_irq_q   <= 1'b0;
      warn_armed_q <= 1'b0;
      cause_q      <= 2'b00;
      running_q    <= 1'b0;
    end else begin
      warn_irq_q <= 1'b0;
      // A new cause bit beats a same-cycle clear.
      cause_q    <= (bus.clear_cause_i ? 2'b00 : cause_q) | cause_set;

      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          presc_q   <= '0;
          sys_rst_q <= 1'b0;
          if (bus.en_i) begin
            state_q      <= RUN;
            running_q    <= 1'b1;
            warn_armed_q <= 1'b1;
          end
        end

        RUN: begin
          if (cause_set != 2'b00) begin
            state_q   <= RST;
            running_q <= 1'b0;
            pulse_q   <= '0;
          end else if (stop_req) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            cnt_q     <= '0;
            presc_q   <= '0;
          end else if (bus.kick_i) begin
            cnt_q        <= '0;
            presc_q      <= '0;
            warn_armed_q <= 1'b1;
          end else if (tick) begin
            presc_q <= '0;
            cnt_q   <= cnt_inc;
            if (warn_armed_q && warn_ok && cnt_inc == cfg_warn && cnt_inc != cnt_q) begin
              warn_irq_q   <= 1'b1;
              warn_armed_q <= 1'b0;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end

        RST: begin
          // pulse_q counts high cycles already issued; sys_rst_q lags entry
          // by one cycle because it is registered.
          if (pulse_q < PulseW'(RstPulseCycles)) begin
            sys_rst_q <= 1'b1;
            pulse_q   <= pulse_q + 1'b1;
          end else begin
            sys_rst_q <= 1'b0;
            pulse_q   <= '0;
            cnt_q     <= '0;
            presc_q   <= '0;
            state_q   <= IDLE;
          end
        end

        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          sys_rst_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sys_rst_o  = sys_rst_q;
  assign bus.warn_irq_o = warn_irq_q;
  assign bus.cause_o    = cause_q;
  assign bus.cnt_o      = cnt_q;
  assign bus.running_o  = running_q;

endmodule
